// File: rtl/spike_rate_encoder.sv
// Rate encoder: turns a latched value/threshold pair into a WINDOW-step spike train.
// Define SPIKE_RATE_ENCODER_COUNT_EN to add the spike_count output.
module spike_rate_encoder #(
  parameter int DATA_WIDTH = 16,
  parameter int WINDOW     = 16
) (
  input  logic                         clk,
  input  logic                         rstn,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic signed [DATA_WIDTH-1:0] in_value,
  input  logic signed [DATA_WIDTH-1:0] threshold,
  input  logic                         step_en,
  output logic                         spike,
  output logic                         spike_valid,
  output logic                         window_done
`ifdef SPIKE_RATE_ENCODER_COUNT_EN
  ,
  output logic [$clog2(WINDOW+1)-1:0]  spike_count
`endif
);

  localparam int AW  = DATA_WIDTH + 1;
  localparam int CW  = $clog2(WINDOW);
  localparam int SCW = $clog2(WINDOW+1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] val_q, thr_q;
  logic [DATA_WIDTH-1:0] val_in, thr_in;
  logic [AW-1:0]         acc_q, acc_sum, acc_diff, acc_nxt, thr_x;
  logic [CW-1:0]         cnt_q;
  logic                  accept, step, fire, last;

  assign in_ready = (state_q == IDLE);

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    step    = 1'b0;
    case (state_q)
      IDLE: if (in_valid) begin
        accept  = 1'b1;
        state_d = RUN;
      end
      RUN: if (step_en) begin
        step = 1'b1;
        if (last) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Negative rates encode as silence; non-positive thresholds fall back to 1.
  always_comb begin
    val_in = in_value[DATA_WIDTH-1] ? '0 : $unsigned(in_value);
    thr_in = (threshold[DATA_WIDTH-1] || (threshold == '0)) ?
             DATA_WIDTH'(1) : $unsigned(threshold);
  end

  // Saturating at thr-1 keeps the accumulator below thr, so one spike per step max.
  always_comb begin
    thr_x    = {1'b0, thr_q};
    acc_sum  = acc_q + {1'b0, val_q};
    fire     = (acc_sum >= thr_x);
    acc_diff = acc_sum - thr_x;
    acc_nxt  = acc_sum;
    if (fire) acc_nxt = (acc_diff >= thr_x) ? (thr_x - AW'(1)) : acc_diff;
    last     = (cnt_q == CW'(WINDOW-1));
  end

  always_ff @(posedge clk) begin
    if (rstn) begin
      state_q     <= IDLE;
      val_q       <= '0;
      thr_q       <= DATA_WIDTH'(1);
      acc_q       <= '0;
      cnt_q       <= '0;
      spike       <= 1'b0;
      spike_valid <= 1'b0;
      window_done <= 1'b0;
    end else begin
      state_q     <= state_d;
      spike       <= 1'b0;
      spike_valid <= 1'b0;
      window_done <= 1'b0;
      if (accept) begin
        val_q <= val_in;
        thr_q <= thr_in;
        acc_q <= '0;
        cnt_q <= '0;
      end
      if (step) begin
        acc_q       <= acc_nxt;
        cnt_q       <= last ? '0 : cnt_q + CW'(1);
        spike       <= fire;
        spike_valid <= 1'b1;
        window_done <= last;
      end
    end
  end

`ifdef SPIKE_RATE_ENCODER_COUNT_EN
  always_ff @(posedge clk) begin
    if (rstn)        spike_count <= '0;
    else if (accept) spike_count <= '0;
    else if (step)   spike_count <= spike_count + SCW'(fire);
  end
`endif

endmodule

// File: tb/tb_spike_rate_encoder.sv
// Directed bench for spike_rate_encoder (WINDOW=16, DATA_WIDTH=16).
module tb_spike_rate_encoder;

  localparam int DW = 16;
  localparam int WIN = 16;

  logic                 clk = 1'b0;
  logic                 rstn, in_valid, in_ready, step_en;
  logic signed [DW-1:0] in_value, threshold;
  logic                 spike, spike_valid, window_done;
`ifdef SPIKE_RATE_ENCODER_COUNT_EN
  logic [$clog2(WIN+1)-1:0] spike_count;
`endif

  int n_chk = 0;
  int n_err = 0;

  spike_rate_encoder #(.DATA_WIDTH(DW), .WINDOW(WIN)) dut (
    .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(in_ready),
    .in_value(in_value), .threshold(threshold), .step_en(step_en),
    .spike(spike), .spike_valid(spike_valid), .window_done(window_done)
`ifdef SPIKE_RATE_ENCODER_COUNT_EN
    , .spike_count(spike_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic accept(input int v, input int t);
    in_valid  = 1'b1;
    in_value  = DW'(v);
    threshold = DW'(t);
    tick();
    in_valid = 1'b0;
    chk("acc_ready", int'(in_ready), 0);
    chk("acc_svalid", int'(spike_valid), 0);
  endtask

  task automatic run_window(input string tag, input logic [WIN-1:0] mask, input int total);
    int n = 0;
    step_en = 1'b1;
    for (int i = 1; i <= WIN; i++) begin
      tick();
      chk({tag, "_sv"}, int'(spike_valid), 1);
      chk({tag, "_spk"}, int'(spike), int'(mask[i-1]));
      chk({tag, "_wd"}, int'(window_done), (i == WIN) ? 1 : 0);
      chk({tag, "_rdy"}, int'(in_ready), (i == WIN) ? 1 : 0);
      if (spike) n++;
    end
    chk({tag, "_total"}, n, total);
`ifdef SPIKE_RATE_ENCODER_COUNT_EN
    chk({tag, "_cnt"}, int'(spike_count), total);
`endif
  endtask

  initial begin
    int k;
    rstn = 1'b1; in_valid = 1'b0; step_en = 1'b0;
    in_value = '0; threshold = '0;
    tick(); tick();
    chk("rst_svalid", int'(spike_valid), 0);
    chk("rst_spike", int'(spike), 0);
    chk("rst_wd", int'(window_done), 0);
    rstn = 1'b0;
    tick();
    chk("rst_ready", int'(in_ready), 1);

    // steady rate: every 4th step
    accept(4, 16);
    run_window("v4t16", 16'h8888, 4);

    // v >= thr fires every step, then v=0 stays silent
    accept(16, 16);
    run_window("v16t16", 16'hFFFF, 16);
    step_en = 1'b1;
    tick();
    chk("idle_svalid", int'(spike_valid), 0);
    chk("idle_wd", int'(window_done), 0);
    accept(0, 16);
    run_window("v0", 16'h0000, 0);

    // clamping of negative value and non-positive threshold
    accept(-5, 16);
    run_window("vneg", 16'h0000, 0);
    accept(3, 0);
    run_window("t0", 16'hFFFF, 16);
    accept(3, -7);
    run_window("tneg", 16'hFFFF, 16);

    // step_en alternating: only enabled edges produce output
    accept(8, 16);
    k = 0;
    for (int c = 0; c < 2*WIN; c++) begin
      step_en = (c % 2 == 0);
      tick();
      if (c % 2 == 0) begin
        k++;
        chk("tog_sv", int'(spike_valid), 1);
        chk("tog_spk", int'(spike), (k % 2 == 0) ? 1 : 0);
        chk("tog_wd", int'(window_done), (k == WIN) ? 1 : 0);
      end else begin
        chk("tog_sv0", int'(spike_valid), 0);
        chk("tog_spk0", int'(spike), 0);
        chk("tog_wd0", int'(window_done), 0);
      end
    end
    chk("tog_steps", k, WIN);
`ifdef SPIKE_RATE_ENCODER_COUNT_EN
    chk("tog_cnt", int'(spike_count), 8);
`endif

    // reset mid-window abandons it; next pair restarts at step 1
    accept(4, 16);
    step_en = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    rstn = 1'b1;
    tick();
    chk("mrst_sv", int'(spike_valid), 0);
    chk("mrst_wd", int'(window_done), 0);
    chk("mrst_rdy", int'(in_ready), 1);
    rstn = 1'b0;
    step_en = 1'b0;
    tick();
    chk("mrst_idle_sv", int'(spike_valid), 0);
    accept(4, 16);
    run_window("post_rst", 16'h8888, 4);

    // in_valid during RUN is ignored; back-to-back acceptance on window_done
    accept(4, 16);
    in_valid  = 1'b1;
    in_value  = DW'(16);
    threshold = DW'(1);
    run_window("ign", 16'h8888, 4);
    in_value  = DW'(16);
    threshold = DW'(16);
    step_en   = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("b2b_ready", int'(in_ready), 0);
    chk("b2b_sv0", int'(spike_valid), 0);
    tick();
    chk("b2b_sv1", int'(spike_valid), 1);
    chk("b2b_spk", int'(spike), 1);
`ifdef SPIKE_RATE_ENCODER_COUNT_EN
    chk("b2b_cnt", int'(spike_count), 1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/spike_rate_encoder.md
SPIKE_RATE_ENCODER -- requirements
Module: spike_rate_encoder

Interface
REQ-001 Parameter DATA_WIDTH, default 16: width of the signed value and threshold inputs.
REQ-002 Parameter WINDOW, default 16: timesteps per encoding window, WINDOW >= 2.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rstn  input  1  synchronous, active-high reset (1 = reset).
REQ-005 in_valid  input  1  value/threshold pair offered.
REQ-006 in_ready  output  1  encoder can accept a pair.
REQ-007 in_value  input  DATA_WIDTH signed  rate value to encode.
REQ-008 threshold  input  DATA_WIDTH signed  firing threshold.
REQ-009 step_en  input  1  advance one timestep this cycle.
REQ-010 spike  output  1  spike for the timestep just processed.
REQ-011 spike_valid  output  1  spike is meaningful this cycle.
REQ-012 window_done  output  1  last timestep of the window is on spike/spike_valid.

Function
REQ-013 The FSM SHALL have two states: IDLE and RUN. in_ready = 1 only in IDLE.
REQ-014 On in_valid && in_ready: latch in_value (negative values clamped to 0) and threshold (values <= 0 replaced by 1); clear the accumulator and step counter; go to RUN.
REQ-015 In RUN with step_en = 1, each edge: acc_sum = acc + value; fire = (acc_sum >= threshold); acc <= fire ? acc_sum - threshold : acc_sum; spike <= fire; spike_valid <= 1; step counter increments.
REQ-016 The accumulator SHALL be DATA_WIDTH+1 bits unsigned. After a subtract it SHALL saturate at threshold-1, so at most one spike fires per timestep and the accumulator never wraps.
REQ-017 In RUN with step_en = 0: hold all state; spike and spike_valid SHALL be 0 in the following cycle.
REQ-018 On the edge that processes timestep WINDOW-1: window_done <= 1 together with that step's spike_valid; FSM goes to IDLE, so in_ready = 1 in the same cycle window_done = 1.
REQ-019 Outputs SHALL be registered. First spike_valid comes no earlier than the cycle after acceptance. window_done, spike and spike_valid are single-cycle pulses per step.
REQ-020 For 0 <= v < threshold, a window SHALL emit floor(WINDOW*v/threshold) spikes. For v >= threshold, it SHALL emit a spike every timestep.
REQ-021 in_valid in RUN SHALL be ignored (not accepted, no effect).

Reset
REQ-022 rstn = 1 at a rising edge SHALL force: IDLE state, accumulator 0, step counter 0, spike 0, spike_valid 0, window_done 0. in_ready SHALL be 1 the cycle after reset releases.
REQ-023 Reset during RUN SHALL abandon the window with no further spike_valid or window_done. Reset overrides a simultaneous handshake or step.

Configuration
REQ-024 Macro SPIKE_RATE_ENCODER_COUNT_EN defined: add output spike_count [$clog2(WINDOW+1)-1:0].
  - Cleared on acceptance; +1 per fired spike.
  - Valid and stable from the window_done cycle until the next acceptance.
  - Reset value 0.
REQ-025 SPIKE_RATE_ENCODER_COUNT_EN undefined: no spike_count port and no counter logic. All other behaviour is identical.

Verification
REQ-026 WINDOW=16, value=4, threshold=16, step_en=1 continuously -> spikes at steps 4, 8, 12, 16 only; window_done on step 16; spike_count=4 if enabled.
REQ-027 value=16, threshold=16 -> spike on all 16 steps. Then value=0 -> zero spikes, window_done still after 16 steps.
REQ-028 value=-5, threshold=16 -> zero spikes (clamped). value=3, threshold=0 -> spike every step (threshold forced to 1).
REQ-029 step_en toggled 1,0,1,0 during RUN with value=8, threshold=16 -> spike_valid only after enabled cycles; spikes at processed steps 2, 4, ..., 16; total 8.
REQ-030 rstn=1 after 5 steps of a window -> next cycle spike_valid=0, window_done=0, in_ready=1. A new pair is then accepted and encodes from step 1.
REQ-031 in_valid held high during RUN with different data -> ignored. Next pair accepted in the window_done cycle, and the first spike_valid follows on the next edge with step_en=1.
